// File: rtl/sha1_wb_master.sv
// sha1_wb_master
// Wishbone classic single-transfer initiator that sequences one SHA-1 block
// through the sha1_wb peripheral: it streams 16 message words into the
// peripheral, writes CTRL to start the hash, polls STATUS until done, reads
// the five digest words back and offers them on a valid/ready output.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   msg_valid/msg_data/msg_ready  message word stream, W0 first
//   wbm_*                      Wishbone classic master port (all registered)
//   digest_o/digest_valid/digest_ready  digest {H0..H4}, H0 in [159:128]
//   busy                       any state other than IDLE and ERR
//   error                      sticky; ack timeout or poll exhaustion
module sha1_wb_master #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          ACK_TIMEOUT = 16,
   parameter int          POLL_GAP    = 4,
   parameter int          POLL_MAX    = 1024
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic         msg_valid,
   input  logic [31:0]  msg_data,
   output logic         msg_ready,
   output logic         wbm_cyc_o,
   output logic         wbm_stb_o,
   output logic         wbm_we_o,
   output logic [3:0]   wbm_sel_o,
   output logic [31:0]  wbm_adr_o,
   output logic [31:0]  wbm_dat_o,
   input  logic [31:0]  wbm_dat_i,
   input  logic         wbm_ack_i,
   output logic [159:0] digest_o,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic         busy,
   output logic         error
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam int PG_W = $clog2(POLL_GAP + 1);
   localparam int PM_W = $clog2(POLL_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_MSG, S_WR_START, S_POLL, S_RD_DIG, S_OUT, S_ERR
   } state_t;

   state_t         state_q, state_d;
   logic           cyc_q, cyc_d;
   logic           we_q, we_d;
   logic [3:0]     sel_q, sel_d;
   logic [31:0]    adr_q, adr_d;
   logic [31:0]    dat_q, dat_d;
   logic [4:0]     wcnt_q, wcnt_d;
   logic [2:0]     dcnt_q, dcnt_d;
   logic [PM_W-1:0] pcnt_q, pcnt_d;
   logic [PG_W-1:0] gap_q, gap_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [159:0]   digest_q, digest_d;
   logic           dvalid_q, dvalid_d;
   logic           error_q, error_d;
   logic           msg_ready_q, msg_ready_d;
   logic           busy_q, busy_d;

   // An ack only counts while our strobe is up.
   logic ack, timeout, accept, poll_last;
   assign ack       = cyc_q & wbm_ack_i;
   assign timeout   = cyc_q & ~wbm_ack_i & (to_q == TO_W'(ACK_TIMEOUT - 1));
   assign accept    = msg_valid & msg_ready_q;
   assign poll_last = (pcnt_q == PM_W'(POLL_MAX - 1));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = S_ERR;
      end else begin
         case (state_q)
            S_IDLE:     if (accept) state_d = S_WR_MSG;
            S_WR_MSG:   if (ack && wcnt_q == 5'd16) state_d = S_WR_START;
            S_WR_START: if (ack) state_d = S_POLL;
            S_POLL: begin
               if (ack) begin
                  if (wbm_dat_i[0])   state_d = S_RD_DIG;
                  else if (poll_last) state_d = S_ERR;
               end
            end
            S_RD_DIG:   if (ack && dcnt_q == 3'd4) state_d = S_OUT;
            S_OUT:      if (digest_ready) state_d = S_IDLE;
            default:    state_d = S_ERR;
         endcase
      end
   end

   always_comb begin
      cyc_d    = cyc_q;
      we_d     = we_q;
      sel_d    = sel_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      wcnt_d   = wcnt_q;
      dcnt_d   = dcnt_q;
      pcnt_d   = pcnt_q;
      gap_d    = gap_q;
      to_d     = to_q;
      digest_d = digest_q;
      dvalid_d = dvalid_q;
      error_d  = error_q;

      // Transfer in flight: hold everything until ack or timeout.
      if (cyc_q) begin
         if (wbm_ack_i || timeout) begin
            cyc_d = 1'b0;
            sel_d = 4'h0;
            to_d  = '0;
            if (timeout) error_d = 1'b1;
         end else begin
            to_d = to_q + 1'b1;
         end
      end

      // Launches only happen with the bus idle, which also yields the
      // mandatory idle cycle after each ack.
      case (state_q)
         S_IDLE, S_WR_MSG: begin
            if (accept) begin
               cyc_d  = 1'b1;
               we_d   = 1'b1;
               sel_d  = 4'hF;
               adr_d  = BASE_ADDR + 32'h10 + {25'd0, wcnt_q, 2'b00};
               dat_d  = msg_data;
               wcnt_d = wcnt_q + 5'd1;
            end
         end
         S_WR_START: begin
            if (!cyc_q) begin
               cyc_d = 1'b1;
               we_d  = 1'b1;
               sel_d = 4'hF;
               adr_d = BASE_ADDR;
               dat_d = 32'h1;
            end
         end
         S_POLL: begin
            if (ack && !wbm_dat_i[0]) begin
               if (pcnt_q != PM_W'(POLL_MAX)) pcnt_d = pcnt_q + 1'b1;
               if (poll_last) error_d = 1'b1;
               // Loaded one short: the launch cycle itself is the last idle one.
               gap_d = PG_W'(POLL_GAP - 1);
            end else if (!cyc_q) begin
               if (gap_q != '0) begin
                  gap_d = gap_q - 1'b1;
               end else begin
                  cyc_d = 1'b1;
                  we_d  = 1'b0;
                  sel_d = 4'hF;
                  adr_d = BASE_ADDR + 32'h4;
               end
            end
         end
         S_RD_DIG: begin
            if (ack) begin
               case (dcnt_q)
                  3'd0:    digest_d[159:128] = wbm_dat_i;
                  3'd1:    digest_d[127:96]  = wbm_dat_i;
                  3'd2:    digest_d[95:64]   = wbm_dat_i;
                  3'd3:    digest_d[63:32]   = wbm_dat_i;
                  default: digest_d[31:0]    = wbm_dat_i;
               endcase
               if (dcnt_q != 3'd7) dcnt_d = dcnt_q + 3'd1;
               if (dcnt_q == 3'd4) dvalid_d = 1'b1;
            end else if (!cyc_q) begin
               cyc_d = 1'b1;
               we_d  = 1'b0;
               sel_d = 4'hF;
               adr_d = BASE_ADDR + 32'h50 + {27'd0, dcnt_q, 2'b00};
            end
         end
         S_OUT: begin
            if (digest_ready) begin
               dvalid_d = 1'b0;
               wcnt_d   = '0;
               dcnt_d   = '0;
               pcnt_d   = '0;
               gap_d    = '0;
            end
         end
         default: ;
      endcase

      msg_ready_d = (state_d == S_IDLE) ||
                    (state_d == S_WR_MSG && !cyc_d && wcnt_d < 5'd16);
      busy_d      = (state_d != S_IDLE) && (state_d != S_ERR);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= 4'h0;
         adr_q       <= 32'h0;
         dat_q       <= 32'h0;
         wcnt_q      <= '0;
         dcnt_q      <= '0;
         pcnt_q      <= '0;
         gap_q       <= '0;
         to_q        <= '0;
         digest_q    <= '0;
         dvalid_q    <= 1'b0;
         error_q     <= 1'b0;
         msg_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         wcnt_q      <= wcnt_d;
         dcnt_q      <= dcnt_d;
         pcnt_q      <= pcnt_d;
         gap_q       <= gap_d;
         to_q        <= to_d;
         digest_q    <= digest_d;
         dvalid_q    <= dvalid_d;
         error_q     <= error_d;
         msg_ready_q <= msg_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign wbm_cyc_o    = cyc_q;
   assign wbm_stb_o    = cyc_q;
   assign wbm_we_o     = we_q;
   assign wbm_sel_o    = sel_q;
   assign wbm_adr_o    = adr_q;
   assign wbm_dat_o    = dat_q;
   assign digest_o     = digest_q;
   assign digest_valid = dvalid_q;
   assign msg_ready    = msg_ready_q;
   assign busy         = busy_q;
   assign error        = error_q;

endmodule

// File: tb/tb_sha1_wb_master.sv
// Testbench for sha1_wb_master: a behavioural sha1_wb slave (computes SHA-1
// of the written block, reports done a fixed time after start) plus a bus
// monitor, driven by a linear sequence of directed and randomized steps.
module tb_sha1_wb_master;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic         msg_valid, msg_ready;
   logic [31:0]  msg_data;
   logic         cyc, stb, we, ack;
   logic [3:0]   sel;
   logic [31:0]  adr, dat_o, dat_i;
   logic [159:0] digest;
   logic         dvalid, dready, busy, error;

   sha1_wb_master #(.BASE_ADDR(BASE), .ACK_TIMEOUT(16), .POLL_GAP(4), .POLL_MAX(1024)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
      .digest_o(digest), .digest_valid(dvalid), .digest_ready(dready),
      .busy(busy), .error(error)
   );

   initial forever #5 clk = ~clk;

   int vec = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Plain FIPS 180 single-block SHA-1 from the standard initial hash.
   function automatic logic [159:0] sha1_ref(input logic [511:0] m);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, t;
      for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
      for (int i = 16; i < 80; i++) w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
      a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
         else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
         t = rotl(a, 5) + f + e + k + w[i];
         e = d; d = c; c = rotl(b, 30); b = a; a = t;
      end
      return {32'h67452301 + a, 32'hEFCDAB89 + b, 32'h98BADCFE + c,
              32'h10325476 + d, 32'hC3D2E1F0 + e};
   endfunction

   // ---------------- behavioural slave ----------------
   logic [511:0] smem;
   logic [159:0] sdig;
   int           scyc = 0, start_cyc = 0, sreads = 0;
   int           min_polls = 0, ack_max = 0;
   logic [31:0]  no_ack_adr = 32'hFFFF_FFFF;

   initial begin
      int  wleft;
      int  idx;
      bit  in_x;
      ack = 1'b0; dat_i = 32'h0; in_x = 0; wleft = 0; smem = '0; sdig = '0;
      forever begin
         @(posedge clk); #2;
         scyc++;
         ack = 1'b0;
         if (rst) begin in_x = 0; continue; end
         if (cyc && stb) begin
            if (!in_x) begin in_x = 1; wleft = $urandom_range(ack_max, 0); end
            if (adr != no_ack_adr) begin
               if (wleft == 0) begin
                  ack = 1'b1; in_x = 0;
                  if (we) begin
                     if (adr == BASE) begin start_cyc = scyc; sreads = 0; sdig = sha1_ref(smem); end
                     else if (adr >= BASE + 32'h10 && adr < BASE + 32'h50) begin
                        idx = int'((adr - BASE - 32'h10) >> 2);
                        smem[511-32*idx -: 32] = dat_o;
                     end
                  end else begin
                     if (adr == BASE + 32'h4) begin
                        dat_i = {31'b0, (scyc - start_cyc >= 10) && (sreads >= min_polls)};
                        sreads++;
                     end else if (adr >= BASE + 32'h50 && adr < BASE + 32'h64) begin
                        idx = int'((adr - BASE - 32'h50) >> 2);
                        dat_i = sdig[159-32*idx -: 32];
                     end else dat_i = 32'h0;
                  end
               end else wleft--;
            end
         end else in_x = 0;
      end
   end

   // ---------------- bus monitor ----------------
   logic [64:0] blog [$];
   int stab_err = 0, sel_err = 0, gap_err = 0, proto_err = 0;
   int run = 0, last_run = 0, nstat = 0, min_gap = 1000, last_stat = 0, mcyc = 0;
   bit have_stat = 0;

   initial begin
      bit pend, prev_ack;
      logic [68:0] prev_bus;
      pend = 0; prev_ack = 0; prev_bus = '0;
      forever begin
         @(negedge clk);
         mcyc++;
         if (rst) begin pend = 0; prev_ack = 0; run = 0; continue; end
         if (cyc !== stb) proto_err++;
         if (prev_ack && cyc) gap_err++;
         if (cyc) begin
            if (sel !== 4'hF) sel_err++;
            if (pend && {we, adr, dat_o, sel} !== prev_bus) stab_err++;
            if (run == 0 && !we && adr == BASE + 32'h4 && have_stat)
               if (mcyc - last_stat - 1 < min_gap) min_gap = mcyc - last_stat - 1;
            run++;
            if (ack) begin
               blog.push_back({we, adr, we ? dat_o : dat_i});
               if (!we && adr == BASE + 32'h4) begin nstat++; last_stat = mcyc; have_stat = 1; end
            end
         end else begin
            if (run > 0) last_run = run;
            run = 0;
         end
         pend     = cyc && !ack;
         prev_ack = cyc && ack;
         prev_bus = {we, adr, dat_o, sel};
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_log();
      blog.delete(); nstat = 0; have_stat = 0; min_gap = 1000;
   endtask

   task automatic send_msg(input logic [511:0] m, input int n, input int maxgap);
      int t;
      for (int i = 0; i < n; i++) begin
         repeat (maxgap > 0 ? $urandom_range(maxgap, 0) : 0) begin @(negedge clk); msg_valid = 1'b0; end
         @(negedge clk); msg_valid = 1'b1; msg_data = m[511-32*i -: 32];
         t = 0;
         while (!msg_ready && t < 300) begin @(negedge clk); t++; end
         if (t >= 300) begin chk("msg_ready_wait", {255'b0, msg_ready}, 256'd1); msg_valid = 1'b0; return; end
         @(posedge clk);
      end
      @(negedge clk); msg_valid = 1'b0;
   endtask

   task automatic wait_digest();
      int t = 0;
      while (!dvalid && t < 5000) begin @(negedge clk); t++; end
      chk("digest_valid_seen", {255'b0, dvalid}, 256'd1);
   endtask

   task automatic take_digest();
      @(negedge clk); dready = 1'b1;
      @(negedge clk);
      chk("dvalid_drop", {255'b0, dvalid}, 256'd0);
      chk("idle_msg_ready", {255'b0, msg_ready}, 256'd1);
      dready = 1'b0;
   endtask

   task automatic check_log(input string tag, input logic [511:0] m, input logic [159:0] d);
      int n = blog.size();
      chk({tag, "_log_len"}, 256'(n), 256'(22 + nstat));
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s_wr%0d", tag, i), 256'(blog[i]),
             256'({1'b1, BASE + 32'h10 + 32'(4*i), m[511-32*i -: 32]}));
      chk({tag, "_start"}, 256'(blog[16]), 256'({1'b1, BASE, 32'h1}));
      for (int j = 0; j < 5; j++)
         chk($sformatf("%s_rd%0d", tag, j), 256'(blog[n-5+j]),
             256'({1'b0, BASE + 32'h50 + 32'(4*j), d[159-32*j -: 32]}));
   endtask

   // ---------------- test sequence ----------------
   localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [159:0] ABC_DIG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

   initial begin
      logic [511:0] m;
      logic [159:0] d0;
      int bad, t;
      rst = 1'b1; msg_valid = 1'b0; msg_data = 32'h0; dready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 256'({cyc, stb, we, sel, adr, dat_o, msg_ready, dvalid, busy, error, digest}), 256'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", {254'b0, msg_ready, busy}, 256'd2);

      // Full hash of "abc", zero-wait slave.
      clear_log(); ack_max = 0; min_polls = 0;
      send_msg(ABC, 16, 0);
      wait_digest();
      chk("abc_digest", 256'(digest), 256'(ABC_DIG));
      chk("abc_error", {255'b0, error}, 256'd0);
      check_log("abc", ABC, ABC_DIG);
      take_digest();

      // Polling: three not-done reads before done.
      clear_log(); min_polls = 3;
      m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send_msg(m, 16, 0);
      wait_digest();
      chk("poll_count", 256'(nstat), 256'd4);
      chk("poll_gap_ok", {255'b0, min_gap >= 4}, 256'd1);
      chk("poll_digest", 256'(digest), 256'(sha1_ref(m)));
      take_digest();
      min_polls = 0;

      // Backpressure on the digest output.
      clear_log(); ack_max = 3;
      send_msg(ABC, 16, 0);
      wait_digest();
      d0 = digest; bad = 0;
      repeat (20) begin @(negedge clk); if (dvalid !== 1'b1 || digest !== d0) bad++; end
      chk("bp_stable", 256'(bad), 256'd0);
      chk("bp_digest", 256'(digest), 256'(ABC_DIG));
      take_digest();

      // Random ack delays and message gaps.
      ack_max = 7;
      for (int b = 0; b < 3; b++) begin
         clear_log();
         m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         send_msg(m, 16, 3);
         wait_digest();
         chk($sformatf("rand%0d_digest", b), 256'(digest), 256'(sha1_ref(m)));
         if (b == 0) check_log("rand0", m, sha1_ref(m));
         take_digest();
      end
      chk("stable_under_wait", 256'(stab_err), 256'd0);

      // Ack timeout on the write of W5.
      ack_max = 1; no_ack_adr = BASE + 32'h24;
      send_msg(ABC, 6, 0);
      t = 0;
      while (!error && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      chk("to_stb_cycles", 256'(last_run), 256'd16);
      chk("to_state", 256'({cyc, stb, error, busy, msg_ready}), 256'(5'b00100));
      msg_valid = 1'b1; bad = 0;
      repeat (20) begin @(negedge clk); if (msg_ready || !error || cyc || busy) bad++; end
      msg_valid = 1'b0;
      chk("to_sticky", 256'(bad), 256'd0);
      no_ack_adr = 32'hFFFF_FFFF;
      do_reset();
      @(negedge clk);
      chk("to_cleared", {254'b0, error, msg_ready}, 256'd1);

      // Reset during the read of H2, then a fresh block.
      ack_max = 2; no_ack_adr = BASE + 32'h58;
      send_msg(ABC, 16, 0);
      t = 0;
      while (!(cyc && adr == BASE + 32'h58) && t < 3000) begin @(negedge clk); t++; end
      chk("h2_read_seen", {255'b0, cyc && adr == BASE + 32'h58}, 256'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_outputs", 256'({cyc, stb, we, sel, adr, dat_o, msg_ready, dvalid, busy, error, digest}), 256'd0);
      @(negedge clk); rst = 1'b0; no_ack_adr = 32'hFFFF_FFFF;
      clear_log();
      send_msg(ABC, 16, 2);
      wait_digest();
      chk("after_rst_digest", 256'(digest), 256'(ABC_DIG));
      take_digest();

      chk("bus_stability", 256'(stab_err), 256'd0);
      chk("sel_during_xfer", 256'(sel_err), 256'd0);
      chk("idle_gap", 256'(gap_err), 256'd0);
      chk("cyc_eq_stb", 256'(proto_err), 256'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
